// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind uart_rx: stores each byte with its parity/frame flags,
// drains first-word-fall-through via valid/ready, and reports overrun and RTS level.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int RTS_HI    = 12,
    parameter int RTS_LO    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_BITS-1:0]      rx_data,
    input  logic                      data_ready,
    input  logic                      parity_err,
    input  logic                      frame_err,
    output logic [DATA_BITS-1:0]      rd_data,
    output logic                      rd_parity_err,
    output logic                      rd_frame_err,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overrun,
    input  logic                      clr_overrun,
    output logic                      rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic          r_rtsN;

    logic [CW-1:0] w_countNext;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = w_valid & rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the write.
    assign w_push  = data_ready & (~w_full | w_pop);
    assign w_drop  = data_ready & ~w_push;

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_rtsN    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
            // Setting wins over a simultaneous clear so no drop is ever lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
            if (w_countNext >= CW'(RTS_HI)) begin
                r_rtsN <= 1'b1;
            end else if (w_countNext <= CW'(RTS_LO)) begin
                r_rtsN <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {frame_err, parity_err, rx_data};
        end
    end

    assign {rd_frame_err, rd_parity_err, rd_data} = r_mem[r_rdPtr];
    assign rd_valid = w_valid;
    assign full     = w_full;
    assign count    = r_count;
    assign overrun  = r_overrun;
    assign rts_n    = r_rtsN;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a scoreboard queue holds every accepted entry,
// and a small occupancy/overrun/RTS model predicts the status outputs each cycle.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int RHI   = 12;
    localparam int RLO   = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          data_ready;
    logic          parity_err;
    logic          frame_err;
    logic [DW-1:0] rd_data;
    logic          rd_parity_err;
    logic          rd_frame_err;
    logic          rd_valid;
    logic          rd_ready;
    logic [4:0]    count;
    logic          full;
    logic          overrun;
    logic          clr_overrun;
    logic          rts_n;

    int            compared;
    int            mismatched;
    int            mCount;
    logic          mOverrun;
    logic          mRts;
    logic [DW+1:0] sbQ [$];

    uart_rx_fifo #(
        .DATA_BITS(DW),
        .DEPTH    (DEPTH),
        .RTS_HI   (RHI),
        .RTS_LO   (RLO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .rd_data      (rd_data),
        .rd_parity_err(rd_parity_err),
        .rd_frame_err (rd_frame_err),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .count        (count),
        .full         (full),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .rts_n        (rts_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_count"},   32'(count),    32'(mCount));
        checkOutput({tag, "_valid"},   32'(rd_valid), 32'(mCount != 0));
        checkOutput({tag, "_full"},    32'(full),     32'(mCount == DEPTH));
        checkOutput({tag, "_overrun"}, 32'(overrun),  32'(mOverrun));
        checkOutput({tag, "_rts_n"},   32'(rts_n),    32'(mRts));
    endtask

    // One clock of stimulus; popped heads are checked against the scoreboard before the edge.
    task automatic applyStimulus(input string tag, input logic push, input logic [DW-1:0] data,
                                 input logic pe, input logic fe, input logic pop, input logic clr);
        logic          mPop;
        logic          mPush;
        logic [DW+1:0] exp;
        data_ready  = push;
        rx_data     = data;
        parity_err  = pe;
        frame_err   = fe;
        rd_ready    = pop;
        clr_overrun = clr;
        mPop  = pop && (mCount != 0);
        mPush = push && ((mCount < DEPTH) || mPop);
        if (mPop) begin
            exp = sbQ.pop_front();
            checkOutput({tag, "_head"}, 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(exp));
        end
        @(posedge clk);
        #1;
        if (push && !mPush) begin
            mOverrun = 1'b1;
        end else if (clr) begin
            mOverrun = 1'b0;
        end
        if (mPush) begin
            sbQ.push_back({fe, pe, data});
        end
        mCount = mCount + (mPush ? 1 : 0) - (mPop ? 1 : 0);
        if (mCount >= RHI) begin
            mRts = 1'b1;
        end else if (mCount <= RLO) begin
            mRts = 1'b0;
        end
        data_ready  = 1'b0;
        rd_ready    = 1'b0;
        clr_overrun = 1'b0;
        checkStatus(tag);
    endtask

    task automatic pushByte(input string tag, input logic [DW-1:0] data, input logic pe, input logic fe);
        applyStimulus(tag, 1'b1, data, pe, fe, 1'b0, 1'b0);
    endtask

    task automatic popByte(input string tag);
        applyStimulus(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic doReset(input string tag);
        reset       = 1'b0;
        data_ready  = 1'b0;
        rd_ready    = 1'b0;
        clr_overrun = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        mCount   = 0;
        mOverrun = 1'b0;
        mRts     = 1'b0;
        sbQ.delete();
        checkStatus(tag);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        mCount      = 0;
        mOverrun    = 1'b0;
        mRts        = 1'b0;
        reset       = 1'b0;
        rx_data     = '0;
        data_ready  = 1'b0;
        parity_err  = 1'b0;
        frame_err   = 1'b0;
        rd_ready    = 1'b0;
        clr_overrun = 1'b0;
        @(posedge clk);
        doReset("reset");

        $display("[TB] single byte");
        pushByte("single_push", 8'hA5, 1'b1, 1'b0);
        checkOutput("single_data",   32'(rd_data),       32'h0000_00A5);
        checkOutput("single_parity", 32'(rd_parity_err), 32'd1);
        checkOutput("single_frame",  32'(rd_frame_err),  32'd0);
        checkOutput("single_count",  32'(count),         32'd1);
        popByte("single_pop");
        checkOutput("single_empty", 32'(rd_valid), 32'd0);

        $display("[TB] fill and wrap");
        for (int i = 0; i < DEPTH; i++) begin
            pushByte("fill_push", 8'(i), i[1], i[0]);
        end
        checkOutput("fill_full",  32'(full),  32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            popByte("fill_pop");
        end
        pushByte("wrap_first", 8'h20, 1'b0, 1'b1);
        for (int i = 1; i < 20; i++) begin
            applyStimulus("wrap_pp", 1'b1, 8'(8'h20 + i), i[0], i[2], 1'b1, 1'b0);
        end
        popByte("wrap_last");

        $display("[TB] overrun");
        for (int i = 0; i < DEPTH; i++) begin
            pushByte("ovr_fill", 8'(8'h80 + i), 1'b0, 1'b0);
        end
        pushByte("ovr_drop", 8'h55, 1'b1, 1'b1);
        checkOutput("ovr_set",   32'(overrun), 32'd1);
        checkOutput("ovr_count", 32'(count),   32'd16);
        checkOutput("ovr_head",  32'(rd_data), 32'h0000_0080);
        applyStimulus("ovr_clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);
        applyStimulus("ovr_setclr", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_set_wins", 32'(overrun), 32'd1);
        applyStimulus("ovr_clr2", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] full push and pop");
        applyStimulus("full_pp", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("full_pp_count",   32'(count),   32'd16);
        checkOutput("full_pp_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            popByte("full_drain");
        end
        checkOutput("full_last_data", 32'(rd_data), 32'h0000_0077);
        popByte("full_last_pop");

        $display("[TB] hysteresis");
        for (int i = 0; i < RHI - 1; i++) begin
            pushByte("hys_push", 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        checkOutput("hys_rts_11", 32'(rts_n), 32'd0);
        pushByte("hys_push12", 8'hCB, 1'b0, 1'b0);
        checkOutput("hys_rts_12", 32'(rts_n), 32'd1);
        for (int i = 0; i < 7; i++) begin
            popByte("hys_pop");
        end
        checkOutput("hys_count_5", 32'(count), 32'd5);
        checkOutput("hys_rts_5",   32'(rts_n), 32'd1);
        popByte("hys_pop4");
        checkOutput("hys_rts_4", 32'(rts_n), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pushByte("hys_refill", 8'(8'hD0 + i), 1'b1, 1'b0);
        end
        checkOutput("hys_count_11", 32'(count), 32'd11);
        checkOutput("hys_rts_11b",  32'(rts_n), 32'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 5; i++) begin
            pushByte("mid_fill", 8'(8'hE0 + i), 1'b0, 1'b1);
        end
        pushByte("mid_drop", 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            popByte("mid_pop");
        end
        checkOutput("mid_count_7", 32'(count),   32'd7);
        checkOutput("mid_overrun", 32'(overrun), 32'd1);
        doReset("mid_reset");
        checkOutput("mid_rst_count", 32'(count),    32'd0);
        checkOutput("mid_rst_valid", 32'(rd_valid), 32'd0);
        checkOutput("mid_rst_ovr",   32'(overrun),  32'd0);
        checkOutput("mid_rst_rts",   32'(rts_n),    32'd0);
        pushByte("post_push", 8'h3C, 1'b0, 1'b0);
        checkOutput("post_data", 32'(rd_data), 32'h0000_003C);
        popByte("post_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_rx. Captures each byte pulsed out on data_ready together with its parity and frame error flags, and holds them in a first-word-fall-through FIFO. The host/bus side drains the FIFO with a valid/ready handshake. The block also reports overrun, occupancy and an RTS-style flow-control level with hysteresis.

Parameters:
DATA_BITS, 8, width of rx_data; matches uart_rx DATA_BITS
DEPTH, 16, number of entries; must be a power of two, at least 4
RTS_HI, 12, occupancy at or above which rts_n goes high (stop sending); must be at most DEPTH
RTS_LO, 4, occupancy at or below which rts_n returns low; must be less than RTS_HI

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset; asserted when 0
rx_data  in  DATA_BITS  byte from uart_rx; valid only in the cycle data_ready is 1
data_ready  in  1  one-cycle write strobe from uart_rx
parity_err  in  1  parity error flag for the current byte; qualified by data_ready
frame_err  in  1  stop-bit error flag for the current byte; qualified by data_ready
rd_data  out  DATA_BITS  head-of-FIFO byte
rd_parity_err  out  1  parity flag stored with the head byte
rd_frame_err  out  1  frame flag stored with the head byte
rd_valid  out  1  head entry is valid (FIFO not empty)
rd_ready  in  1  consumer accepts the head entry when rd_valid is also 1
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
overrun  out  1  sticky: a byte was dropped because the FIFO was full
clr_overrun  in  1  one-cycle pulse that clears overrun
rts_n  out  1  flow control; 0 = OK to send, 1 = stop

Behaviour:
- Storage: DEPTH entries of {frame_err, parity_err, rx_data}, i.e. DATA_BITS+2 bits each. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in the count register.
- Reset values (reset==0 at a clk edge): pointers=0, count=0, full=0, rd_valid=0, overrun=0, rts_n=0. Memory contents are don't-care. Reset mid-traffic discards all entries immediately.
- Write: when data_ready=1 and (count<DEPTH or a pop occurs in the same cycle), the entry is written at wr_ptr and wr_ptr increments.
- Pop: when rd_valid=1 and rd_ready=1, rd_ptr increments. rd_ready while rd_valid=0 is ignored; there is no underflow.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: the write is accepted and count stays at DEPTH; no overrun.
- Full with push and no pop: the byte is dropped, overrun is set to 1, and the FIFO is unchanged.
- overrun priority: a set in the same cycle as clr_overrun wins, so overrun stays 1.
- Latency: a byte strobed at edge N gives rd_valid=1 with that data/flags after edge N (visible in cycle N+1). rd_data, rd_parity_err and rd_frame_err are combinational reads of mem[rd_ptr]. They are stable while rd_valid=1 and no pop occurs; they are don't-care when rd_valid=0.
- rd_valid = (count != 0); full = (count == DEPTH); both are derived from the count register.
- rts_n register is evaluated on next-state count:
  - next count >= RTS_HI: rts_n goes to 1.
  - next count <= RTS_LO: rts_n goes to 0.
  - otherwise rts_n holds its value (hysteresis).
- Error flags do not block storage: erroneous bytes are stored and the consumer decides what to do with them.
- Ordering is strict FIFO; flags always travel with their own byte.

Test Plan:
- Reset then single byte: release reset; pulse data_ready with rx_data=0xA5, parity_err=1 -> next cycle rd_valid=1, rd_data=0xA5, rd_parity_err=1, rd_frame_err=0, count=1. Pop -> rd_valid=0, count=0.
- Fill and wrap: push 0x00..0x0F (DEPTH=16) -> full=1, count=16. Pop all -> values out in order. Push/pop 20 more bytes -> correct order across pointer wrap.
- Overrun: with FIFO full, push 0x55 without pop -> overrun=1, count=16, head unchanged. Pulse clr_overrun -> overrun=0. Set and clear in the same cycle -> overrun=1.
- Full with simultaneous push and pop: push 0x77 and pop together -> count=16, overrun=0, 0x77 emerges last.
- Hysteresis: push 12 bytes -> rts_n=1 in the cycle after the 12th push. Pop to count=5 -> rts_n still 1. Pop to count=4 -> rts_n=0. Push to 11 -> rts_n still 0.
- Reset mid-operation: with count=7 and overrun=1, drive reset=0 for one edge -> count=0, rd_valid=0, overrun=0, rts_n=0. A subsequent push of 0x3C reads back 0x3C.
